// File: rtl/peripheral_gpio_irq.sv
// Avalon-MM GPIO: synchronised/debounced inputs with edge-capture IRQ, set/clear outputs; read latency 1.
// Never backpressures: waitrequest is tied low and every accepted read returns data on the next cycle.
module peripheral_gpio_irq #(
  parameter int          IN_WIDTH        = 3,
  parameter int          OUT_WIDTH       = 8,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] IN_RESET        = 32'h0,
  parameter logic [31:0] OUT_RESET       = 32'h0
) (
  input  logic                 clk_in_clk,
  input  logic                 reset_in_reset_n,
  input  logic [2:0]           s0_address,
  input  logic                 s0_read,
  input  logic                 s0_write,
  input  logic [3:0]           s0_byteenable,
  input  logic [31:0]          s0_writedata,
  output logic [31:0]          s0_readdata,
  output logic                 s0_readdatavalid,
  output logic                 s0_waitrequest,
  input  logic [IN_WIDTH-1:0]  gpio_in,
  output logic [OUT_WIDTH-1:0] gpio_out,
  output logic                 irq
);

  localparam logic [IN_WIDTH-1:0]  LP_IN_RST  = IN_RESET[IN_WIDTH-1:0];
  localparam logic [OUT_WIDTH-1:0] LP_OUT_RST = OUT_RESET[OUT_WIDTH-1:0];

  logic [31:0]          w_be_mask;
  logic [31:0]          w_wd_m;
  logic                 w_wr_out, w_wr_set, w_wr_clr, w_wr_mask, w_wr_cap, w_wr_pol;
  logic [IN_WIDTH-1:0]  r_sync1, r_sync2, w_stable, r_stable_q;
  logic [IN_WIDTH-1:0]  w_rise, w_fall, w_edge, w_cap_clr;
  logic [IN_WIDTH-1:0]  r_mask, r_cap, r_pol;
  logic [OUT_WIDTH-1:0] r_dout;
  logic [31:0]          w_rd, r_rdata;
  logic                 r_rvalid, r_irq;
  logic                 w_unused;

  assign w_be_mask = {{8{s0_byteenable[3]}}, {8{s0_byteenable[2]}},
                      {8{s0_byteenable[1]}}, {8{s0_byteenable[0]}}};
  assign w_wd_m    = s0_writedata & w_be_mask;
  assign w_unused  = ^{w_wd_m, w_be_mask};

  assign w_wr_out  = s0_write && (s0_address == 3'd1);
  assign w_wr_set  = s0_write && (s0_address == 3'd2);
  assign w_wr_clr  = s0_write && (s0_address == 3'd3);
  assign w_wr_mask = s0_write && (s0_address == 3'd4);
  assign w_wr_cap  = s0_write && (s0_address == 3'd5);
  assign w_wr_pol  = s0_write && (s0_address == 3'd6);

  always_ff @(posedge clk_in_clk or negedge reset_in_reset_n) begin
    if (!reset_in_reset_n) begin
      r_sync1 <= LP_IN_RST;
      r_sync2 <= LP_IN_RST;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign w_stable = r_sync2;
  end else begin : g_debounce
    localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LP_LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [CW-1:0]       r_cnt [IN_WIDTH];
    logic [IN_WIDTH-1:0] r_stable;

    // A channel only flips once it has differed for DEBOUNCE_CYCLES consecutive clocks.
    always_ff @(posedge clk_in_clk or negedge reset_in_reset_n) begin
      if (!reset_in_reset_n) begin
        r_stable <= LP_IN_RST;
        for (int i = 0; i < IN_WIDTH; i++) r_cnt[i] <= '0;
      end else begin
        for (int i = 0; i < IN_WIDTH; i++) begin
          if (r_sync2[i] == r_stable[i]) begin
            r_cnt[i] <= '0;
          end else if (r_cnt[i] == LP_LAST) begin
            r_stable[i] <= r_sync2[i];
            r_cnt[i]    <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end
      end
    end
    assign w_stable = r_stable;
  end

  assign w_rise    = w_stable & ~r_stable_q;
  assign w_fall    = ~w_stable & r_stable_q;
  assign w_edge    = (w_rise & ~r_pol) | (w_fall & r_pol);
  assign w_cap_clr = w_wr_cap ? w_wd_m[IN_WIDTH-1:0] : '0;

  // New edges are OR-ed in after the W1C so a coincident edge wins.
  always_ff @(posedge clk_in_clk or negedge reset_in_reset_n) begin
    if (!reset_in_reset_n) begin
      r_stable_q <= LP_IN_RST;
      r_mask     <= '0;
      r_pol      <= '0;
      r_cap      <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_stable_q <= w_stable;
      r_cap      <= (r_cap & ~w_cap_clr) | w_edge;
      r_irq      <= |(r_cap & r_mask);
      if (w_wr_mask)
        r_mask <= (r_mask & ~w_be_mask[IN_WIDTH-1:0]) | w_wd_m[IN_WIDTH-1:0];
      if (w_wr_pol)
        r_pol <= (r_pol & ~w_be_mask[IN_WIDTH-1:0]) | w_wd_m[IN_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_in_clk or negedge reset_in_reset_n) begin
    if (!reset_in_reset_n) begin
      r_dout <= LP_OUT_RST;
    end else if (w_wr_out) begin
      r_dout <= (r_dout & ~w_be_mask[OUT_WIDTH-1:0]) | w_wd_m[OUT_WIDTH-1:0];
    end else if (w_wr_set) begin
      r_dout <= r_dout | w_wd_m[OUT_WIDTH-1:0];
    end else if (w_wr_clr) begin
      r_dout <= r_dout & ~w_wd_m[OUT_WIDTH-1:0];
    end
  end

  always_comb begin
    w_rd = '0;
    case (s0_address)
      3'd0:    w_rd[IN_WIDTH-1:0]  = w_stable;
      3'd1:    w_rd[OUT_WIDTH-1:0] = r_dout;
      3'd4:    w_rd[IN_WIDTH-1:0]  = r_mask;
      3'd5:    w_rd[IN_WIDTH-1:0]  = r_cap;
      3'd6:    w_rd[IN_WIDTH-1:0]  = r_pol;
      default: w_rd = '0;
    endcase
  end

  always_ff @(posedge clk_in_clk or negedge reset_in_reset_n) begin
    if (!reset_in_reset_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= s0_read;
      if (s0_read) r_rdata <= w_rd;
    end
  end

  assign s0_readdata      = r_rdata;
  assign s0_readdatavalid = r_rvalid;
  assign s0_waitrequest   = 1'b0;
  assign gpio_out         = r_dout;
  assign irq              = r_irq;

endmodule

// File: tb/tb_peripheral_gpio_irq.sv
// Directed bench: default-parameter instance plus a narrow-in/wide-out bypass instance on a shared bus.
module tb_peripheral_gpio_irq;

  logic        clk;
  logic        rst_n;
  logic [2:0]  addr;
  logic        s0_rd;
  logic        s0_wr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [2:0]  gin1;
  logic [0:0]  gin2;
  logic [31:0] rdata1, rdata2;
  logic        rv1, rv2, wq1, wq2, irq1, irq2;
  logic [7:0]  gout1;
  logic [31:0] gout2;
  int          checks;
  int          errors;

  peripheral_gpio_irq dut1 (
    .clk_in_clk(clk), .reset_in_reset_n(rst_n),
    .s0_address(addr), .s0_read(s0_rd), .s0_write(s0_wr),
    .s0_byteenable(be), .s0_writedata(wdata),
    .s0_readdata(rdata1), .s0_readdatavalid(rv1), .s0_waitrequest(wq1),
    .gpio_in(gin1), .gpio_out(gout1), .irq(irq1)
  );

  peripheral_gpio_irq #(
    .IN_WIDTH(1), .OUT_WIDTH(32), .DEBOUNCE_CYCLES(0)
  ) dut2 (
    .clk_in_clk(clk), .reset_in_reset_n(rst_n),
    .s0_address(addr), .s0_read(s0_rd), .s0_write(s0_wr),
    .s0_byteenable(be), .s0_writedata(wdata),
    .s0_readdata(rdata2), .s0_readdatavalid(rv2), .s0_waitrequest(wq2),
    .gpio_in(gin2), .gpio_out(gout2), .irq(irq2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
    addr  = a;
    wdata = d;
    be    = b;
    s0_wr = 1'b1;
    tick();
    s0_wr = 1'b0;
    be    = 4'h0;
  endtask

  task automatic rd(input logic [2:0] a);
    addr  = a;
    s0_rd = 1'b1;
    tick();
    s0_rd = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk = 1'b0; rst_n = 1'b0; addr = '0; s0_rd = 1'b0; s0_wr = 1'b0;
    be = '0; wdata = '0; gin1 = '0; gin2 = '0;
    #1;
    chk("rst_gout1", {24'h0, gout1}, 32'h0);
    chk("rst_irq1", {31'h0, irq1}, 32'h0);
    chk("rst_rv1", {31'h0, rv1}, 32'h0);
    chk("rst_gout2", gout2, 32'h0);
    chk("waitreq", {30'h0, wq1, wq2}, 32'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Output register, set and clear
    wr(3'd1, 32'hA5, 4'hF);    chk("out_write", {24'h0, gout1}, 32'hA5);
    wr(3'd2, 32'h0A, 4'hF);    chk("out_set", {24'h0, gout1}, 32'hAF);
    wr(3'd3, 32'h81, 4'hF);    chk("out_clr", {24'h0, gout1}, 32'h2E);
    wr(3'd1, 32'hFFFF, 4'h0);  chk("out_be0", {24'h0, gout1}, 32'h2E);
    chk("out_be0_wide", gout2, 32'h2E);
    rd(3'd1);
    chk("rd_out_vld", {31'h0, rv1}, 32'h1);
    chk("rd_out", rdata1, 32'h2E);
    rd(3'd2);                  chk("rd_set_zero", rdata1, 32'h0);
    tick();                    chk("rv_idle", {31'h0, rv1}, 32'h0);

    // Debounce: 10-clock glitch is rejected
    gin1 = 3'b001;
    repeat (10) tick();
    gin1 = 3'b000;
    repeat (25) tick();
    rd(3'd0);                  chk("glitch_din", rdata1, 32'h0);
    rd(3'd5);                  chk("glitch_cap", rdata1, 32'h0);

    // Held high: DATA_IN changes on the 18th clock after the pin change
    gin1 = 3'b001;
    repeat (17) tick();
    addr = 3'd0; s0_rd = 1'b1;
    tick();
    chk("din_edge18_vld", {31'h0, rv1}, 32'h1);
    chk("din_edge18", rdata1, 32'h0);
    tick();
    chk("din_edge19_vld", {31'h0, rv1}, 32'h1);
    chk("din_edge19", rdata1, 32'h1);
    s0_rd = 1'b0;
    rd(3'd5);                  chk("rise_cap", rdata1, 32'h1);
    chk("irq_masked", {31'h0, irq1}, 32'h0);
    wr(3'd5, 32'h1, 4'hF);
    rd(3'd5);                  chk("cap_w1c", rdata1, 32'h0);

    // Falling-edge capture on channel 1
    wr(3'd4, 32'h7, 4'hF);
    wr(3'd6, 32'h2, 4'hF);
    rd(3'd6);                  chk("pol_rd", rdata1, 32'h2);
    gin1 = 3'b011;
    repeat (25) tick();
    rd(3'd5);                  chk("ch1_rise_ignored", rdata1, 32'h0);
    chk("ch1_rise_noirq", {31'h0, irq1}, 32'h0);
    gin1 = 3'b001;
    repeat (19) tick();
    chk("irq_pre", {31'h0, irq1}, 32'h0);
    tick();
    chk("irq_fall", {31'h0, irq1}, 32'h1);
    rd(3'd5);                  chk("fall_cap", rdata1, 32'h2);
    wr(3'd5, 32'h2, 4'hF);
    chk("irq_clr_same", {31'h0, irq1}, 32'h1);
    tick();
    chk("irq_clr_next", {31'h0, irq1}, 32'h0);
    rd(3'd5);                  chk("cap_clr", rdata1, 32'h0);

    // Clear colliding with a new rising edge on channel 0
    gin1 = 3'b000;
    repeat (25) tick();
    gin1 = 3'b001;
    repeat (25) tick();
    chk("ch0_irq", {31'h0, irq1}, 32'h1);
    gin1 = 3'b000;
    repeat (25) tick();
    gin1 = 3'b001;
    repeat (18) tick();
    wr(3'd5, 32'h1, 4'hF);
    chk("coll_irq0", {31'h0, irq1}, 32'h1);
    tick();
    chk("coll_irq1", {31'h0, irq1}, 32'h1);
    rd(3'd5);                  chk("coll_cap", rdata1, 32'h1);
    wr(3'd6, 32'h0, 4'hF);
    rd(3'd5);                  chk("pol_keeps_cap", rdata1, 32'h1);

    // Bypass instance: 1 input, 32 outputs
    gin2 = 1'b1;
    tick();
    addr = 3'd0; s0_rd = 1'b1;
    tick();                    chk("byp_edge2", rdata2, 32'h0);
    tick();                    chk("byp_edge3", rdata2, 32'h1);
    s0_rd = 1'b0;
    rd(3'd5);                  chk("byp_cap", rdata2, 32'h1);
    chk("byp_irq", {31'h0, irq2}, 32'h1);
    rd(3'd7);
    chk("rsvd_wide", rdata2, 32'h0);
    chk("rsvd_narrow", rdata1, 32'h0);
    wr(3'd1, 32'hFFFFFFFF, 4'b0101);
    chk("be_partial_wide", gout2, 32'h00FF00FF);
    chk("be_partial_narrow", {24'h0, gout1}, 32'hFF);
    wr(3'd1, 32'hFFFFFFFF, 4'hF);
    chk("out_all_ones", gout2, 32'hFFFFFFFF);
    wr(3'd4, 32'hFFFFFFFF, 4'hF);
    rd(3'd4);
    chk("mask_wide_upper", rdata2, 32'h1);
    chk("mask_narrow_upper", rdata1, 32'h7);

    // Asynchronous reset in the middle of a read
    addr = 3'd0; s0_rd = 1'b1;
    tick();
    chk("pre_rst_vld", {31'h0, rv1}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", {31'h0, rv1}, 32'h0);
    chk("mid_rst_gout1", {24'h0, gout1}, 32'h0);
    chk("mid_rst_irq1", {31'h0, irq1}, 32'h0);
    chk("mid_rst_gout2", gout2, 32'h0);
    chk("mid_rst_irq2", {31'h0, irq2}, 32'h0);
    s0_rd = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {31'h0, rv1}, 32'h0);
    rd(3'd0);
    chk("post_rst_vld", {31'h0, rv1}, 32'h1);
    chk("post_rst_din", rdata1, 32'h0);
    tick();
    chk("post_rst_vld_drop", {31'h0, rv1}, 32'h0);
    rd(3'd5);                  chk("post_rst_cap", rdata1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
